// File: rtl/rf_wb_arbiter_pkg.sv
// rtl/rf_wb_arbiter_pkg.sv - shared widths and MDU result entry type for the RF write arbiter
package rf_wb_arbiter_pkg;

    localparam int REG_W  = 5;
    localparam int DATA_W = 32;

    typedef struct packed {
        logic [REG_W-1:0]  a3;
        logic [DATA_W-1:0] wd;
        logic [DATA_W-1:0] pc;
    } mdu_entry_t;

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// rtl/rf_wb_arbiter_if.sv - W-stage, MDU, decode and RF write-port signal bundle
interface rf_wb_arbiter_if;
    import rf_wb_arbiter_pkg::*;

    logic              wb_we;
    logic [REG_W-1:0]  wb_a3;
    logic [DATA_W-1:0] wb_wd;
    logic [DATA_W-1:0] wb_pc;
    logic              mdu_issue;
    logic [REG_W-1:0]  mdu_issue_a3;
    logic              mdu_valid;
    logic [REG_W-1:0]  mdu_a3;
    logic [DATA_W-1:0] mdu_wd;
    logic [DATA_W-1:0] mdu_pc;
    logic              mdu_ready;
    logic [REG_W-1:0]  dec_a1;
    logic [REG_W-1:0]  dec_a2;
    logic [REG_W-1:0]  dec_a3;
    logic              dec_stall;
    logic              wb_stall;
    logic              RFWe;
    logic [REG_W-1:0]  A3;
    logic [DATA_W-1:0] RF_WD;
    logic [DATA_W-1:0] WPC;

    modport master (
        output wb_we, wb_a3, wb_wd, wb_pc,
        output mdu_issue, mdu_issue_a3, mdu_valid, mdu_a3, mdu_wd, mdu_pc,
        output dec_a1, dec_a2, dec_a3,
        input  mdu_ready, dec_stall, wb_stall, RFWe, A3, RF_WD, WPC
    );

    modport slave (
        input  wb_we, wb_a3, wb_wd, wb_pc,
        input  mdu_issue, mdu_issue_a3, mdu_valid, mdu_a3, mdu_wd, mdu_pc,
        input  dec_a1, dec_a2, dec_a3,
        output mdu_ready, dec_stall, wb_stall, RFWe, A3, RF_WD, WPC
    );

endinterface

// File: rtl/rf_wb_fifo.sv
// rtl/rf_wb_fifo.sv - MDU result FIFO with wrap-around pointers, occupancy count and head peek
module rf_wb_fifo
    import rf_wb_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  mdu_entry_t push_data,
    input  logic       pop,
    output mdu_entry_t head,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    mdu_entry_t     mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [CW-1:0]  count;
    logic           do_push;
    logic           do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (!do_push && do_pop) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - RF write-port arbiter between W stage and buffered MDU results
module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int STARVE = 4
) (
    input  logic           clk,
    input  logic           reset,
    rf_wb_arbiter_if.slave bus
);

    localparam int SW = $clog2(STARVE + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE);

    mdu_entry_t     head;
    mdu_entry_t     push_data;
    logic           full;
    logic           empty;
    logic           push;
    logic           deq;
    logic           force_mdu;
    logic           wb_req;
    logic [SW-1:0]  starve;
    logic [31:0]    busy;
    logic [31:0]    busy_next;

    assign push_data     = '{a3: bus.mdu_a3, wd: bus.mdu_wd, pc: bus.mdu_pc};
    assign bus.mdu_ready = !reset && !full;
    assign push          = bus.mdu_valid && bus.mdu_ready;
    assign force_mdu     = full && (starve == STARVE_MAX);
    assign wb_req        = bus.wb_we && (bus.wb_a3 != '0);

    rf_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (deq),
        .head      (head),
        .full      (full),
        .empty     (empty)
    );

    // A head entry with a3==0 still takes its slot but never enables the write.
    always_comb begin
        deq          = 1'b0;
        bus.RFWe     = 1'b0;
        bus.A3       = '0;
        bus.RF_WD    = '0;
        bus.WPC      = '0;
        bus.wb_stall = 1'b0;
        if (!reset) begin
            if (force_mdu || (!wb_req && !empty)) begin
                deq          = 1'b1;
                bus.RFWe     = (head.a3 != '0);
                bus.A3       = head.a3;
                bus.RF_WD    = head.wd;
                bus.WPC      = head.pc;
                bus.wb_stall = force_mdu && wb_req;
            end else if (wb_req) begin
                bus.RFWe  = 1'b1;
                bus.A3    = bus.wb_a3;
                bus.RF_WD = bus.wb_wd;
                bus.WPC   = bus.wb_pc;
            end
        end
    end

    // A new issue to the same register outranks the clear from the draining write.
    always_comb begin
        busy_next = busy;
        if (deq && head.a3 != '0) begin
            busy_next[head.a3] = 1'b0;
        end
        if (bus.mdu_issue && bus.mdu_issue_a3 != '0) begin
            busy_next[bus.mdu_issue_a3] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy   <= '0;
            starve <= '0;
        end else begin
            busy <= busy_next;
            if (deq || !full) begin
                starve <= '0;
            end else if (starve != STARVE_MAX) begin
                starve <= starve + 1'b1;
            end
        end
    end

    assign bus.dec_stall = !reset && (busy[bus.dec_a1] | busy[bus.dec_a2] | busy[bus.dec_a3]);

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb/tb_rf_wb_arbiter.sv - scoreboard bench for rf_wb_arbiter with a queue-based reference model
module tb_rf_wb_arbiter;
    import rf_wb_arbiter_pkg::*;

    localparam int DEPTH  = 2;
    localparam int STARVE = 4;

    typedef struct {
        logic        rfwe;
        logic [4:0]  a3;
        logic [31:0] wd;
        logic [31:0] pc;
        logic        wbs;
        logic        decs;
        logic        rdy;
        logic        chk_data;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    rf_wb_arbiter_if bus();

    rf_wb_arbiter #(.DEPTH(DEPTH), .STARVE(STARVE)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // stimulus variables applied by step()
    logic        s_rst = 1'b1;
    logic        s_we = 0;
    logic [4:0]  s_wa3 = 0;
    logic [31:0] s_wd = 0, s_wpc = 0;
    logic        s_iss = 0;
    logic [4:0]  s_ia3 = 0;
    logic        s_mv = 0;
    logic [4:0]  s_ma3 = 0;
    logic [31:0] s_md = 0, s_mpc = 0;
    logic [4:0]  s_d1 = 0, s_d2 = 0, s_d3 = 0;

    // reference model state
    mdu_entry_t mq[$];
    bit         busy_m[32];
    int         starve_m = 0;
    bit         acc_m;
    exp_t       exp_q[$];

    task automatic step();
        exp_t e;
        bit full, forced, wreq, take;
        mdu_entry_t h;
        @(posedge clk);
        #1;
        reset            = s_rst;
        bus.wb_we        = s_we;   bus.wb_a3  = s_wa3; bus.wb_wd = s_wd; bus.wb_pc = s_wpc;
        bus.mdu_issue    = s_iss;  bus.mdu_issue_a3 = s_ia3;
        bus.mdu_valid    = s_mv;   bus.mdu_a3 = s_ma3; bus.mdu_wd = s_md; bus.mdu_pc = s_mpc;
        bus.dec_a1       = s_d1;   bus.dec_a2 = s_d2;  bus.dec_a3 = s_d3;

        e = '{rfwe: 0, a3: 0, wd: 0, pc: 0, wbs: 0, decs: 0, rdy: 0, chk_data: 0};
        acc_m = 0;
        if (s_rst) begin
            e.chk_data = 1;
            mq.delete();
            foreach (busy_m[i]) busy_m[i] = 0;
            starve_m = 0;
        end else begin
            full   = (mq.size() == DEPTH);
            forced = full && (starve_m == STARVE);
            wreq   = s_we && (s_wa3 != 0);
            take   = forced || (!wreq && mq.size() > 0);
            e.rdy  = !full;
            e.decs = busy_m[s_d1] || busy_m[s_d2] || busy_m[s_d3];
            if (take) begin
                h = mq.pop_front();
                e.rfwe = (h.a3 != 0);
                e.a3 = h.a3; e.wd = h.wd; e.pc = h.pc;
                e.wbs = forced && wreq;
                if (h.a3 != 0) busy_m[h.a3] = 0;
            end else if (wreq) begin
                e.rfwe = 1; e.a3 = s_wa3; e.wd = s_wd; e.pc = s_wpc;
            end
            e.chk_data = e.rfwe;
            if (s_iss && s_ia3 != 0) busy_m[s_ia3] = 1;
            if (s_mv && !full) begin
                mq.push_back('{a3: s_ma3, wd: s_md, pc: s_mpc});
                acc_m = 1;
            end
            if (take || !full) starve_m = 0;
            else if (starve_m < STARVE) starve_m++;
        end
        exp_q.push_back(e);
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // monitor: compares the DUT against the oldest queued expectation mid-cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("RFWe", 32'(bus.RFWe), 32'(e.rfwe));
                chk("wb_stall", 32'(bus.wb_stall), 32'(e.wbs));
                chk("dec_stall", 32'(bus.dec_stall), 32'(e.decs));
                chk("mdu_ready", 32'(bus.mdu_ready), 32'(e.rdy));
                if (e.chk_data) begin
                    chk("A3", 32'(bus.A3), 32'(e.a3));
                    chk("RF_WD", bus.RF_WD, e.wd);
                    chk("WPC", bus.WPC, e.pc);
                end
            end
        end
    end

    task automatic idle();
        s_rst = 0; s_we = 0; s_wa3 = 0; s_iss = 0; s_mv = 0;
    endtask

    initial begin
        int tries;
        // reset
        s_rst = 1; step(); step();
        idle();

        // issue a3=8, result DEADBEEF, watch dec_stall on rs=8
        s_d1 = 8; s_d2 = 0; s_d3 = 0;
        s_iss = 1; s_ia3 = 8; step();
        s_iss = 0; s_mv = 1; s_ma3 = 8; s_md = 32'hDEADBEEF; s_mpc = 32'h0000_1000; step();
        s_mv = 0; step(); step(); step();

        // W writes a3=3 continuously while one MDU result waits
        s_mv = 1; s_ma3 = 12; s_md = 32'h1234_5678; s_mpc = 32'h2000;
        s_we = 1; s_wa3 = 3; s_wd = 32'h33; s_wpc = 32'h100; step();
        s_mv = 0;
        for (int i = 0; i < 3; i++) begin s_wd = 32'h40 + i; s_wpc = 32'h104 + 4 * i; step(); end
        s_we = 0; step(); step();

        // fill FIFO while W is busy, then starve until forced
        s_we = 1; s_wa3 = 3;
        s_mv = 1; s_ma3 = 9;  s_md = 32'h9999; s_mpc = 32'h3000; s_wd = 32'h50; step();
        s_ma3 = 10; s_md = 32'hAAAA; s_mpc = 32'h3004; s_wd = 32'h51; step();
        s_ma3 = 11; s_md = 32'hBBBB; s_mpc = 32'h3008;
        for (int i = 0; i < 8; i++) begin
            s_wd = 32'h60 + i;
            step();
            if (acc_m) s_mv = 0;
        end
        s_we = 0; s_mv = 0;
        for (int i = 0; i < 4; i++) step();

        // ordering across pointer wrap, with backpressure at full
        for (int i = 0; i < 8; i++) begin
            s_mv = 1; s_ma3 = 5'(16 + i); s_md = 32'hC000 + i; s_mpc = 32'h4000 + 4 * i;
            tries = 0;
            do begin
                s_we = (i < 4); s_wa3 = 7; s_wd = 32'h70 + tries;
                step();
                tries++;
            end while (!acc_m && tries < 20);
            if (!acc_m) chk("wrap_accept_timeout", 0, 1);
        end
        idle();
        for (int i = 0; i < 10; i++) step();

        // a3==0 result and a3==0 W write
        s_mv = 1; s_ma3 = 0; s_md = 32'hF00D; s_mpc = 32'h5000; step();
        s_mv = 0; step();
        s_we = 1; s_wa3 = 0; s_wd = 32'hBAD; step();
        idle(); step();

        // reset with pending entries and busy 5,6
        s_d1 = 5; s_d2 = 6;
        s_we = 1; s_wa3 = 2;
        s_iss = 1; s_ia3 = 5; step();
        s_ia3 = 6; s_mv = 1; s_ma3 = 5; s_md = 32'h55; step();
        s_iss = 0; s_ma3 = 6; s_md = 32'h66; step();
        s_mv = 0; step();
        s_rst = 1; step();
        idle(); step(); step();

        // randomized traffic with a holding MDU producer
        s_mv = 0;
        for (int c = 0; c < 3000; c++) begin
            s_rst = ($urandom_range(0, 299) == 0);
            s_we  = ($urandom_range(0, 99) < ((c / 500) % 2 ? 85 : 45));
            s_wa3 = 5'($urandom_range(0, 7));
            s_wd  = $urandom; s_wpc = $urandom;
            s_iss = ($urandom_range(0, 3) == 0);
            s_ia3 = 5'($urandom_range(0, 7));
            if (!s_mv) begin
                s_mv  = ($urandom_range(0, 2) == 0);
                s_ma3 = 5'($urandom_range(0, 7));
                s_md  = $urandom; s_mpc = $urandom;
            end
            s_d1 = 5'($urandom_range(0, 7));
            s_d2 = 5'($urandom_range(0, 7));
            s_d3 = 5'($urandom_range(0, 7));
            step();
            if (acc_m || s_rst) s_mv = 0;
        end
        idle(); step(); step();

        tries = 0;
        while (exp_q.size() > 0 && tries < 10) begin @(posedge clk); tries++; end
        if (exp_q.size() > 0) chk("drain_timeout", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
